// File: rtl/target_arb_pkg.sv
// Shared types and constants for the target programming pin arbiter.
package target_arb_pkg;
  localparam int NREQ_DEF = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GUARD = 2'd2
  } arb_state_e;

  localparam logic [1:0] OWNER_AVRISP = 2'd0;
  localparam logic [1:0] OWNER_PDI    = 2'd1;
  localparam logic [1:0] OWNER_GPIO   = 2'd2;
  localparam logic [1:0] OWNER_NONE   = 2'd3;
endpackage

// File: rtl/target_arb_watchdog.sv
// Grant watchdog: counts idle GRANT cycles, saturates, flags when the limit is hit.
module target_arb_watchdog #(
  parameter int TIMEOUT_W = 24
) (
  input  logic                 clk,
  input  logic                 reset_i,
  input  logic                 clear,
  input  logic                 run,
  input  logic                 kick,
  input  logic [TIMEOUT_W-1:0] limit,
  output logic                 expire
);
  logic [TIMEOUT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset_i)
    if (reset_i)               cnt_q <= '0;
    else if (clear || kick)    cnt_q <= '0;
    else if (run && cnt_q != '1) cnt_q <= cnt_q + 1'b1;

  // a zero limit disables the watchdog
  assign expire = run && (limit != '0) && (cnt_q == limit);
endmodule

// File: rtl/target_pin_arbiter.sv
// Single-owner arbiter for the shared target pins with a high-Z guard on hand-over.
// Optional grant watchdog enabled by defining TARGET_ARB_TIMEOUT_EN.
module target_pin_arbiter
  import target_arb_pkg::*;
#(
  parameter int NREQ         = NREQ_DEF,
  parameter int GUARD_CYCLES = 16,
  parameter int TIMEOUT_W    = 24
) (
  input  logic                 clk,
  input  logic                 reset_i,
  input  logic [NREQ-1:0]      req_i,
  input  logic [NREQ-1:0]      activity_i,
  input  logic                 target_highz_i,
  input  logic [TIMEOUT_W-1:0] timeout_cfg_i,
  output logic [NREQ-1:0]      grant_o,
  output logic                 drive_en_o,
  output logic [1:0]           owner_o,
  output logic                 guard_o,
  output logic                 revoked_o
);
  localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;

  arb_state_e      state_q, state_d;
  logic [NREQ-1:0] grant_d, elig, win_oh, mask_q;
  logic [1:0]      owner_d, win;
  logic [GW-1:0]   gcnt_q, gcnt_d;
  logic            win_vld, found, owner_req, wd_clr, wd_expire, revoke_d;

  // lowest eligible index wins
  always_comb begin
    elig  = req_i & ~mask_q;
    found = 1'b0;
    win   = OWNER_NONE;
    for (int k = 0; k < NREQ; k++)
      if (elig[k] && !found) begin
        found = 1'b1;
        win   = 2'(k);
      end
    win_vld = found && !target_highz_i;
    win_oh  = NREQ'(1) << win;
  end

  assign owner_req = |(req_i & grant_o);

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_o;
    owner_d  = owner_o;
    gcnt_d   = gcnt_q;
    revoke_d = 1'b0;
    wd_clr   = 1'b0;
    case (state_q)
      ST_IDLE:
        if (win_vld) begin
          state_d = ST_GRANT;
          grant_d = win_oh;
          owner_d = win;
          wd_clr  = 1'b1;
        end
      ST_GRANT:
        if (!owner_req || target_highz_i || wd_expire) begin
          state_d  = ST_GUARD;
          grant_d  = '0;
          owner_d  = OWNER_NONE;
          gcnt_d   = GW'(GUARD_CYCLES - 1);
          // a release or high-Z in the same cycle wins over the watchdog
          revoke_d = wd_expire && owner_req && !target_highz_i;
        end
      ST_GUARD:
        if (gcnt_q == '0) begin
          if (win_vld) begin
            state_d = ST_GRANT;
            grant_d = win_oh;
            owner_d = win;
            wd_clr  = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          gcnt_d = gcnt_q - 1'b1;
        end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset_i)
    if (reset_i) begin
      state_q <= ST_IDLE;
      grant_o <= '0;
      owner_o <= OWNER_NONE;
      gcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_o <= grant_d;
      owner_o <= owner_d;
      gcnt_q  <= gcnt_d;
    end

  assign drive_en_o = |grant_o;
  assign guard_o    = (state_q == ST_GUARD);

`ifdef TARGET_ARB_TIMEOUT_EN
  target_arb_watchdog #(.TIMEOUT_W(TIMEOUT_W)) u_wd (
    .clk     (clk),
    .reset_i (reset_i),
    .clear   (wd_clr),
    .run     (state_q == ST_GRANT),
    .kick    (|(activity_i & grant_o)),
    .limit   (timeout_cfg_i),
    .expire  (wd_expire)
  );

  // a revoked requester stays locked out until it drops its request once
  always_ff @(posedge clk or posedge reset_i)
    if (reset_i) begin
      mask_q    <= '0;
      revoked_o <= 1'b0;
    end else begin
      mask_q    <= (mask_q & req_i) | (revoke_d ? grant_o : '0);
      revoked_o <= revoke_d;
    end
`else
  logic unused_wd;
  assign unused_wd = ^{activity_i, timeout_cfg_i, wd_clr, revoke_d};
  assign wd_expire = 1'b0;
  assign mask_q    = '0;
  assign revoked_o = 1'b0;
`endif
endmodule

// File: tb/tb_target_pin_arbiter.sv
// Scoreboard bench for target_pin_arbiter; watchdog checks follow TARGET_ARB_TIMEOUT_EN.
module tb_target_pin_arbiter;
  localparam int NREQ  = 3;
  localparam int GUARD = 16;
  localparam int TW    = 24;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NREQ-1:0] req = '0;
  logic [NREQ-1:0] act = '0;
  logic            hz  = 1'b0;
  logic [TW-1:0]   cfg = '0;
  logic [NREQ-1:0] grant_o;
  logic            drive_en_o, guard_o, revoked_o;
  logic [1:0]      owner_o;

  target_pin_arbiter #(.NREQ(NREQ), .GUARD_CYCLES(GUARD), .TIMEOUT_W(TW)) dut (
    .clk            (clk),
    .reset_i        (rst),
    .req_i          (req),
    .activity_i     (act),
    .target_highz_i (hz),
    .timeout_cfg_i  (cfg),
    .grant_o        (grant_o),
    .drive_en_o     (drive_en_o),
    .owner_o        (owner_o),
    .guard_o        (guard_o),
    .revoked_o      (revoked_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // expected output word: {grant, drive_en, owner, guard, revoked}
  typedef logic [7:0] exp_t;
  exp_t sb[$];

  int            m_st;   // 0 idle, 1 grant, 2 guard
  logic [2:0]    m_g, m_mask, m_el;
  logic [1:0]    m_own;
  int            m_gc, m_w;
  logic          m_rv;
  logic [TW-1:0] m_wd;

  function automatic int lowest(input logic [2:0] v);
    for (int k = 0; k < 3; k++) if (v[k]) return k;
    return -1;
  endfunction

  task automatic m_grant(input int w);
    m_g = 3'b001 << w; m_own = 2'(w); m_st = 1; m_wd = '0;
  endtask

  task automatic m_release();
    m_g = '0; m_own = 2'd3; m_gc = GUARD - 1; m_st = 2;
  endtask

  task automatic model_step();
    m_rv = 1'b0;
    if (rst) begin
      m_st = 0; m_g = '0; m_own = 2'd3; m_gc = 0; m_mask = '0; m_wd = '0;
    end else begin
      m_el   = req & ~m_mask;
      m_w    = hz ? -1 : lowest(m_el);
      m_mask = m_mask & req;
      case (m_st)
        0: if (m_w >= 0) m_grant(m_w);
        1: begin
          if (!req[m_own] || hz) m_release();
`ifdef TARGET_ARB_TIMEOUT_EN
          else if (cfg != 0 && m_wd == cfg) begin
            m_mask[m_own] = 1'b1; m_rv = 1'b1; m_release();
          end
          else if (act[m_own]) m_wd = '0;
          else if (m_wd != '1) m_wd = m_wd + 1'b1;
`endif
        end
        default: begin
          if (m_gc == 0) begin
            if (m_w >= 0) m_grant(m_w); else m_st = 0;
          end else m_gc--;
        end
      endcase
    end
    sb.push_back({m_g, |m_g, m_own, m_st == 2, m_rv});
  endtask

  always @(posedge clk) model_step();

  always @(negedge clk)
    if (sb.size() > 0) chk("cyc", {24'd0, grant_o, drive_en_o, owner_o, guard_o, revoked_o}, {24'd0, sb.pop_front()});

  // waits (bounded) until the guard interval has finished
  task automatic wait_guard_end(input string tag);
    int n = 0;
    @(negedge clk);
    while (guard_o && n < 200) begin n++; @(negedge clk); end
    if (n >= 200) chk({tag, "_timeout"}, 32'(guard_o), 32'd0);
  endtask

  initial begin
    int n, revs;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_owner", 32'(owner_o), 32'd3);
    chk("rst_grant", 32'(grant_o), 32'd0);
    chk("rst_guard", 32'(guard_o), 32'd0);

    // single request: one registered stage of latency
    req = 3'b010;
    @(negedge clk);
    chk("t1_grant", 32'(grant_o), 32'b010);
    chk("t1_owner", 32'(owner_o), 32'd1);
    chk("t1_drive", 32'(drive_en_o), 32'd1);

    // priority then hand-over through a full guard
    req = 3'b000;
    wait_guard_end("t2_pre");
    req = 3'b110;
    @(negedge clk);
    chk("t2_prio", 32'(grant_o), 32'b010);
    repeat (3) @(negedge clk);
    req = 3'b100;
    @(negedge clk);
    n = 0;
    while (guard_o && grant_o == '0 && n < 100) begin n++; @(negedge clk); end
    chk("t2_guard_len", 32'(n), 32'(GUARD));
    chk("t2_handover", 32'(grant_o), 32'b100);
    chk("t2_owner", 32'(owner_o), 32'd2);

    // high-Z override: release, guard runs out, IDLE held until high-Z drops
    repeat (2) @(negedge clk);
    hz = 1'b1;
    @(negedge clk);
    chk("t3_drop", 32'(grant_o), 32'd0);
    chk("t3_guard", 32'(guard_o), 32'd1);
    wait_guard_end("t3");
    repeat (5) @(negedge clk);
    chk("t3_hold", 32'(grant_o), 32'd0);
    hz = 1'b0;
    @(negedge clk);
    chk("t3_regrant", 32'(grant_o), 32'b100);

    // release and high-Z together: ordinary release into guard
    req = 3'b000; hz = 1'b1;
    @(negedge clk);
    chk("t3b_guard", 32'(guard_o), 32'd1);
    hz = 1'b0;
    wait_guard_end("t3b");

    // watchdog behaviour
    cfg = TW'(100);
    req = 3'b001;
    @(negedge clk);
    chk("wd_grant", 32'(grant_o), 32'b001);
`ifdef TARGET_ARB_TIMEOUT_EN
    n = 0;
    while (!revoked_o && n < 300) begin n++; @(negedge clk); end
    // counter hits the limit after cfg GRANT cycles, grant drops one edge later
    chk("wd_latency", 32'(n), 32'd101);
    chk("wd_drop", 32'(grant_o), 32'd0);
    wait_guard_end("wd");
    repeat (5) @(negedge clk);
    chk("wd_masked", 32'(grant_o), 32'd0);
    req = 3'b000;
    @(negedge clk);
    req = 3'b001;
    @(negedge clk);
    chk("wd_regrant", 32'(grant_o), 32'b001);
    revs = 0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      act = (i % 50 == 0) ? 3'b001 : 3'b000;
      if (revoked_o) revs++;
    end
    act = '0;
    chk("wd_kick", 32'(revs), 32'd0);
`else
    revs = 0;
    repeat (300) begin @(negedge clk); if (revoked_o) revs++; end
    chk("wd_off_rev", 32'(revs), 32'd0);
    chk("wd_off_hold", 32'(grant_o), 32'b001);
`endif
    cfg = '0;
    revs = 0;
    repeat (500) begin @(negedge clk); if (revoked_o) revs++; end
    chk("wd_zero", 32'(revs), 32'd0);
    chk("wd_zero_hold", 32'(grant_o), 32'b001);

    // asynchronous reset mid-grant
    #2 rst = 1'b1;
    #1;
    chk("arst_grant", 32'(grant_o), 32'd0);
    chk("arst_owner", 32'(owner_o), 32'd3);
    chk("arst_drive", 32'(drive_en_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("arst_regrant", 32'(grant_o), 32'b001);

    req = 3'b000;
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
